// File: rtl/decode_issue_stage.sv
// RV32I decode/issue stage: one decode slot, one issue register, 32-entry
// pending-write scoreboard with RAW/WAW stall, valid/ready hand-off to EX.
//
// Ports:
//   i_clk, i_rst            clock, async active-high reset
//   i_if_valid/o_if_ready   fetch handshake with i_if_instr, i_if_pc
//   o_addr_srcA/B           register_file read indices (rs1/rs2 of slot)
//   i_dataA/B               register_file read data (combinational)
//   i_wb_valid, i_wb_rd     write-back retirement, clears busy bit
//   i_flush                 kills slot and issue register
//   o_ex_* / i_ex_ready     issue register contents and EX handshake
//   o_stall                 slot occupied but blocked
module decode_issue_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_if_valid,
    output logic                  o_if_ready,
    input  logic [31:0]           i_if_instr,
    input  logic [XLEN-1:0]       i_if_pc,
    output logic [REG_ADDR_W-1:0] o_addr_srcA,
    output logic [REG_ADDR_W-1:0] o_addr_srcB,
    input  logic [XLEN-1:0]       i_dataA,
    input  logic [XLEN-1:0]       i_dataB,
    input  logic                  i_wb_valid,
    input  logic [REG_ADDR_W-1:0] i_wb_rd,
    input  logic                  i_flush,
    output logic                  o_ex_valid,
    input  logic                  i_ex_ready,
    output logic [XLEN-1:0]       o_ex_pc,
    output logic [XLEN-1:0]       o_ex_rs1_data,
    output logic [XLEN-1:0]       o_ex_rs2_data,
    output logic [XLEN-1:0]       o_ex_imm,
    output logic [REG_ADDR_W-1:0] o_ex_rd,
    output logic [6:0]            o_ex_opcode,
    output logic [2:0]            o_ex_funct3,
    output logic                  o_ex_funct7b5,
    output logic                  o_ex_reg_write,
    output logic                  o_ex_illegal,
    output logic                  o_stall
);
    localparam int NREG = 1 << REG_ADDR_W;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;
    localparam logic [6:0] OPC_SYS    = 7'b1110011;

    typedef enum logic {SLOT_EMPTY, SLOT_OCC} slot_state_t;
    typedef enum logic {ISS_EMPTY, ISS_FULL} iss_state_t;

    slot_state_t slot_q, slot_d;
    iss_state_t  iss_q, iss_d;

    logic [31:0]           ins;
    logic [XLEN-1:0]       slot_pc;
    logic [NREG-1:0]       busy, busy_d;

    logic [6:0]            opc;
    logic [REG_ADDR_W-1:0] rs1, rs2, rd;
    logic is_op, is_opimm, is_load, is_store, is_branch;
    logic is_lui, is_auipc, is_jal, is_jalr, is_misc, is_sys;
    logic fmt_i, fmt_u, illegal;
    logic use_rs1, use_rs2, reg_write, hazard;
    logic slot_occ, iss_full, issue, accept;
    logic [XLEN-1:0] imm;

    assign opc = ins[6:0];
    assign rd  = ins[7 +: REG_ADDR_W];
    assign rs1 = ins[15 +: REG_ADDR_W];
    assign rs2 = ins[20 +: REG_ADDR_W];

    assign is_op     = (opc == OPC_OP);
    assign is_opimm  = (opc == OPC_OPIMM);
    assign is_load   = (opc == OPC_LOAD);
    assign is_store  = (opc == OPC_STORE);
    assign is_branch = (opc == OPC_BRANCH);
    assign is_lui    = (opc == OPC_LUI);
    assign is_auipc  = (opc == OPC_AUIPC);
    assign is_jal    = (opc == OPC_JAL);
    assign is_jalr   = (opc == OPC_JALR);
    assign is_misc   = (opc == OPC_MISC);
    assign is_sys    = (opc == OPC_SYS);

    assign fmt_i   = is_opimm | is_load | is_jalr | is_misc | is_sys;
    assign fmt_u   = is_lui | is_auipc;
    assign illegal = ~(is_op | fmt_i | is_store | is_branch | fmt_u | is_jal);

    assign use_rs1   = ~(is_lui | is_auipc | is_jal);
    assign use_rs2   = is_op | is_store | is_branch;
    assign reg_write = (is_op | is_opimm | is_load | fmt_u | is_jal | is_jalr)
                     & (rd != '0);

    // busy[0] is held at zero, so x0 never causes a stall
    assign hazard = (use_rs1 & busy[rs1])
                  | (use_rs2 & busy[rs2])
                  | (reg_write & busy[rd]);

    always_comb begin
        imm = '0;
        unique case (1'b1)
            fmt_i:     imm = {{(XLEN-11){ins[31]}}, ins[30:20]};
            is_store:  imm = {{(XLEN-11){ins[31]}}, ins[30:25], ins[11:7]};
            is_branch: imm = {{(XLEN-12){ins[31]}}, ins[7], ins[30:25],
                              ins[11:8], 1'b0};
            fmt_u:     imm = {{(XLEN-31){ins[31]}}, ins[30:12], 12'b0};
            is_jal:    imm = {{(XLEN-20){ins[31]}}, ins[19:12], ins[20],
                              ins[30:21], 1'b0};
            default:   imm = '0;
        endcase
    end

    assign slot_occ = (slot_q == SLOT_OCC);
    assign iss_full = (iss_q == ISS_FULL);
    assign issue    = slot_occ & ~hazard & (~iss_full | i_ex_ready) & ~i_flush;
    assign accept   = i_if_valid & o_if_ready & ~i_flush;

    assign o_if_ready  = ~slot_occ | issue;
    assign o_addr_srcA = rs1;
    assign o_addr_srcB = rs2;
    assign o_ex_valid  = iss_full;
    assign o_stall     = slot_occ & (hazard | (iss_full & ~i_ex_ready));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            slot_q <= SLOT_EMPTY;
            iss_q  <= ISS_EMPTY;
            busy   <= '0;
        end else begin
            slot_q <= slot_d;
            iss_q  <= iss_d;
            busy   <= busy_d;
        end
    end

    always_comb begin
        slot_d = slot_q;
        iss_d  = iss_q;
        if (i_flush) begin
            slot_d = SLOT_EMPTY;
        end else if (accept) begin
            slot_d = SLOT_OCC;
        end else if (issue) begin
            slot_d = SLOT_EMPTY;
        end
        if (i_flush) begin
            iss_d = ISS_EMPTY;
        end else if (issue) begin
            iss_d = ISS_FULL;
        end else if (i_ex_ready) begin
            iss_d = ISS_EMPTY;
        end
    end

    // clears first so a same-edge set on the same index wins
    always_comb begin
        busy_d = busy;
        if (i_wb_valid) begin
            busy_d[i_wb_rd] = 1'b0;
        end
        if (i_flush & iss_full & o_ex_reg_write) begin
            busy_d[o_ex_rd] = 1'b0;
        end
        if (issue & reg_write) begin
            busy_d[rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ins     <= '0;
            slot_pc <= '0;
        end else if (accept) begin
            ins     <= i_if_instr;
            slot_pc <= i_if_pc;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_ex_pc        <= '0;
            o_ex_rs1_data  <= '0;
            o_ex_rs2_data  <= '0;
            o_ex_imm       <= '0;
            o_ex_rd        <= '0;
            o_ex_opcode    <= '0;
            o_ex_funct3    <= '0;
            o_ex_funct7b5  <= 1'b0;
            o_ex_reg_write <= 1'b0;
            o_ex_illegal   <= 1'b0;
        end else if (issue) begin
            o_ex_pc        <= slot_pc;
            o_ex_rs1_data  <= i_dataA;
            o_ex_rs2_data  <= i_dataB;
            o_ex_imm       <= imm;
            o_ex_rd        <= rd;
            o_ex_opcode    <= opc;
            o_ex_funct3    <= ins[14:12];
            o_ex_funct7b5  <= ins[30];
            o_ex_reg_write <= reg_write;
            o_ex_illegal   <= illegal;
        end
    end
endmodule

// File: tb/tb_decode_issue_stage.sv
// Scoreboard bench for decode_issue_stage: directed scenarios followed by
// randomized traffic against a program-order reference model.
module tb_decode_issue_stage;
    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_if_valid, o_if_ready;
    logic [31:0] i_if_instr, i_if_pc;
    logic [4:0]  addr_a, addr_b;
    logic [31:0] data_a, data_b;
    logic        i_wb_valid;
    logic [4:0]  i_wb_rd;
    logic        i_flush, o_ex_valid, i_ex_ready;
    logic [31:0] o_ex_pc, o_ex_rs1_data, o_ex_rs2_data, o_ex_imm;
    logic [4:0]  o_ex_rd;
    logic [6:0]  o_ex_opcode;
    logic [2:0]  o_ex_funct3;
    logic        o_ex_funct7b5, o_ex_reg_write, o_ex_illegal, o_stall;

    always #5 clk = ~clk;

    decode_issue_stage dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_if_valid(i_if_valid), .o_if_ready(o_if_ready),
        .i_if_instr(i_if_instr), .i_if_pc(i_if_pc),
        .o_addr_srcA(addr_a), .o_addr_srcB(addr_b),
        .i_dataA(data_a), .i_dataB(data_b),
        .i_wb_valid(i_wb_valid), .i_wb_rd(i_wb_rd),
        .i_flush(i_flush),
        .o_ex_valid(o_ex_valid), .i_ex_ready(i_ex_ready),
        .o_ex_pc(o_ex_pc), .o_ex_rs1_data(o_ex_rs1_data),
        .o_ex_rs2_data(o_ex_rs2_data), .o_ex_imm(o_ex_imm),
        .o_ex_rd(o_ex_rd), .o_ex_opcode(o_ex_opcode),
        .o_ex_funct3(o_ex_funct3), .o_ex_funct7b5(o_ex_funct7b5),
        .o_ex_reg_write(o_ex_reg_write), .o_ex_illegal(o_ex_illegal),
        .o_stall(o_stall)
    );

    typedef struct {
        logic [31:0] pc, imm;
        logic [4:0]  rd, rs1, rs2;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7, rw, ill, u1, u2;
        int          seq;
    } exp_t;

    typedef struct {
        logic [4:0] rd;
        int         seq;
        int         due;
    } wb_t;

    exp_t        expq[$];
    wb_t         wbq[$];
    logic [31:0] rf[32];
    logic [31:0] expval[32];
    logic [6:0]  ops[12];
    int          nchk = 0, nerr = 0;
    int          cyc = 0, seq = 0;
    logic [31:0] next_pc = 32'h1000;
    bit          auto_wb = 0;
    bit          wb_pend = 0;
    logic [4:0]  pend_rd;
    int          pend_seq;

    assign data_a = rf[addr_a];
    assign data_b = rf[addr_b];

    task automatic chk(input string nm, input logic [159:0] act,
                       input logic [159:0] req);
        nchk++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] wval(input int sq);
        return 32'(sq) * 32'h9E3779B1 + 32'h12345677;
    endfunction

    function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
        logic [31:0] m;
        m = 32'd1 << (bits - 1);
        return (v ^ m) - m;
    endfunction

    // Reference decode: format and write/read rules from the RV32I tables
    function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc,
                                   input int sq);
        exp_t e;
        int   fmt;
        bit   wr, legal;
        e.pc = pc; e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
        e.opc = w[6:0]; e.f3 = w[14:12]; e.f7 = w[30]; e.seq = sq;
        fmt = 0; wr = 0; legal = 1;
        case (w[6:0])
            7'h33:               wr = 1;
            7'h13, 7'h03, 7'h67: begin wr = 1; fmt = 1; end
            7'h0F, 7'h73:        fmt = 1;
            7'h23:               fmt = 2;
            7'h63:               fmt = 3;
            7'h37, 7'h17:        begin wr = 1; fmt = 4; end
            7'h6F:               begin wr = 1; fmt = 5; end
            default:             legal = 0;
        endcase
        e.ill = !legal;
        e.rw  = wr && (w[11:7] != 0);
        e.u1  = !(w[6:0] == 7'h37 || w[6:0] == 7'h17 || w[6:0] == 7'h6F);
        e.u2  = (w[6:0] == 7'h33 || w[6:0] == 7'h23 || w[6:0] == 7'h63);
        case (fmt)
            1:       e.imm = sx(w >> 20, 12);
            2:       e.imm = sx({20'd0, w[31:25], w[11:7]}, 12);
            3:       e.imm = sx({19'd0, w[31], w[7], w[30:25], w[11:8], 1'b0}, 13);
            4:       e.imm = w & 32'hFFFFF000;
            5:       e.imm = sx({11'd0, w[31], w[19:12], w[20], w[30:21], 1'b0}, 21);
            default: e.imm = 32'd0;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        w[6:0]   = ops[$urandom_range(0, 11)];
        w[11:7]  = 5'($urandom_range(0, 5));
        w[19:15] = 5'($urandom_range(0, 5));
        w[24:20] = 5'($urandom_range(0, 5));
        return w;
    endfunction

    task automatic commit_wb();
        if (wb_pend) begin
            rf[pend_rd] = wval(pend_seq);
            wb_pend = 0;
        end
    endtask

    // One clock: drive at posedge+1, record acceptance at the negedge
    task automatic cycle(input bit v, input logic [31:0] w, input bit rdy,
                         input bit fl, input bit do_wb);
        wb_t b;
        @(posedge clk);
        commit_wb();
        #1;
        i_wb_valid = 0;
        i_wb_rd    = 0;
        if (wbq.size() > 0 &&
            ((auto_wb && wbq[0].due <= cyc) || (!auto_wb && do_wb))) begin
            b = wbq.pop_front();
            i_wb_valid = 1;
            i_wb_rd    = b.rd;
            wb_pend    = 1;
            pend_rd    = b.rd;
            pend_seq   = b.seq;
        end
        i_if_valid = v;
        i_if_instr = w;
        i_if_pc    = next_pc;
        i_ex_ready = rdy;
        i_flush    = fl;
        @(negedge clk);
        if (fl) begin
            expq.delete();
        end else if (v && o_if_ready) begin
            expq.push_back(model(w, next_pc, seq));
            seq++;
            next_pc += 4;
        end
        cyc++;
    endtask

    task automatic drain(input string nm);
        for (int k = 0; k < 200; k++) begin
            if (expq.size() == 0 && wbq.size() == 0 && !o_ex_valid) break;
            cycle(0, 0, 1, 0, 1);
        end
        cycle(0, 0, 1, 0, 0);
        chk(nm, 160'(expq.size() + wbq.size()), 160'd0);
    endtask

    task automatic reset_outputs(input string nm);
        chk({nm, "_valid"}, o_ex_valid, 0);
        chk({nm, "_stall"}, o_stall, 0);
        chk({nm, "_ex"}, {o_ex_pc, o_ex_rs1_data, o_ex_rs2_data, o_ex_imm,
                          o_ex_rd, o_ex_opcode, o_ex_funct3, o_ex_funct7b5,
                          o_ex_reg_write, o_ex_illegal}, 0);
        chk({nm, "_busy"}, dut.busy, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        commit_wb();
        #1;
        i_rst = 1;
        i_if_valid = 0; i_ex_ready = 0; i_flush = 0; i_wb_valid = 0;
        expq.delete();
        wbq.delete();
        @(negedge clk);
        reset_outputs("midrst");
        @(posedge clk);
        #1;
        i_rst = 0;
        foreach (expval[r]) expval[r] = rf[r];
        @(negedge clk);
        chk("midrst_ifready", o_if_ready, 1);
    endtask

    // Monitor: pops the scoreboard whenever EX takes the issue register
    exp_t         me;
    bit           hold = 0;
    logic [145:0] snap;
    logic [145:0] cur;
    assign cur = {o_ex_pc, o_ex_rs1_data, o_ex_rs2_data, o_ex_imm, o_ex_rd,
                  o_ex_opcode, o_ex_funct3, o_ex_funct7b5, o_ex_reg_write,
                  o_ex_illegal};

    always @(negedge clk) begin
        if (i_rst) begin
            hold = 0;
        end else begin
            if (hold) begin
                chk("hold_valid", o_ex_valid, 1);
                chk("hold_stable", cur, snap);
            end
            if (o_ex_valid && i_ex_ready) begin
                if (expq.size() == 0) begin
                    chk("unexpected_issue", o_ex_pc, 0);
                    if (o_ex_pc == 0) begin
                        nerr++;
                        $display("FAIL unexpected_issue: got pc 0 expected none");
                    end
                end else begin
                    me = expq.pop_front();
                    chk("pc", o_ex_pc, me.pc);
                    chk("imm", o_ex_imm, me.imm);
                    chk("rd", o_ex_rd, me.rd);
                    chk("ctl", {o_ex_opcode, o_ex_funct3, o_ex_funct7b5},
                        {me.opc, me.f3, me.f7});
                    chk("reg_write", o_ex_reg_write, me.rw);
                    chk("illegal", o_ex_illegal, me.ill);
                    if (me.u1) chk("rs1_data", o_ex_rs1_data, expval[me.rs1]);
                    if (me.u2) chk("rs2_data", o_ex_rs2_data, expval[me.rs2]);
                    if (me.rw) begin
                        expval[me.rd] = wval(me.seq);
                        wbq.push_back('{rd: me.rd, seq: me.seq,
                                        due: cyc + 1 + $urandom_range(0, 4)});
                    end
                end
            end
            hold = o_ex_valid && !i_ex_ready && !i_flush;
            snap = cur;
        end
    end

    logic [31:0] imm_ins[4];
    logic [31:0] imm_req[4];
    bit          imm_rw[4];

    initial begin
        ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h0F, 7'h73,
                7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7B};
        for (int r = 0; r < 32; r++) begin
            rf[r]     = (r == 0) ? 32'd0 : (32'hA5A50000 | 32'(r));
            expval[r] = rf[r];
        end
        i_rst = 1; i_if_valid = 0; i_if_instr = 0; i_if_pc = 0;
        i_wb_valid = 0; i_wb_rd = 0; i_flush = 0; i_ex_ready = 0;
        repeat (2) @(negedge clk);
        reset_outputs("rst");
        @(posedge clk);
        #1;
        i_rst = 0;

        // ADDI x1 then dependent ADD x2,x1,x1
        cycle(1, 32'h00500093, 0, 0, 0);
        chk("acc_ready", o_if_ready, 1);
        cycle(0, 0, 0, 0, 0);
        chk("lat_valid", o_ex_valid, 0);
        chk("lat_stall", o_stall, 0);
        cycle(1, 32'h00108133, 1, 0, 0);
        chk("addi_valid", o_ex_valid, 1);
        chk("addi_imm", o_ex_imm, 5);
        chk("addi_rd", o_ex_rd, 1);
        chk("busy1", dut.busy[1], 1);
        cycle(0, 0, 1, 0, 0);
        chk("raw_stall0", o_stall, 1);
        chk("raw_novalid", o_ex_valid, 0);
        cycle(0, 0, 1, 0, 0);
        chk("raw_stall1", o_stall, 1);
        cycle(0, 0, 1, 0, 1);
        chk("raw_stall_wb", o_stall, 1);
        cycle(0, 0, 1, 0, 0);
        chk("raw_release", o_stall, 0);
        cycle(0, 0, 1, 0, 0);
        chk("add_valid", o_ex_valid, 1);
        chk("add_rd", o_ex_rd, 2);
        drain("drain_raw");

        // WAW on x3
        cycle(1, 32'h00700193, 1, 0, 0);
        cycle(1, 32'h00900193, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        chk("waw_stall0", o_stall, 1);
        cycle(0, 0, 1, 0, 0);
        chk("waw_stall1", o_stall, 1);
        chk("waw_busy", dut.busy[3], 1);
        cycle(0, 0, 1, 0, 1);
        chk("waw_stall_wb", o_stall, 1);
        cycle(0, 0, 1, 0, 0);
        chk("waw_release", o_stall, 0);
        cycle(0, 0, 1, 0, 0);
        chk("waw_valid", o_ex_valid, 1);
        chk("waw_busy2", dut.busy[3], 1);
        drain("drain_waw");

        // EX backpressure with slot full
        cycle(1, 32'h00500093, 0, 0, 0);
        cycle(1, 32'h00700113, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cycle(1, 32'h00900193, 0, 0, 0);
            chk("bp_ifready", o_if_ready, 0);
            chk("bp_stall", o_stall, 1);
            chk("bp_rd", o_ex_rd, 1);
        end
        cycle(1, 32'h00900193, 1, 0, 0);
        chk("bp_resume", o_if_ready, 1);
        drain("drain_bp");

        // Immediate formats
        imm_ins = '{32'h0020A423, 32'hFE000EE3, 32'h123452B7, 32'h008000EF};
        imm_req = '{32'd8, 32'hFFFFFFFC, 32'h12345000, 32'd8};
        imm_rw  = '{0, 0, 1, 1};
        for (int k = 0; k < 4; k++) begin
            cycle(1, imm_ins[k], 0, 0, 0);
            cycle(0, 0, 0, 0, 0);
            cycle(0, 0, 0, 0, 0);
            chk("imm_fmt", o_ex_imm, imm_req[k]);
            chk("imm_rw", o_ex_reg_write, imm_rw[k]);
            cycle(0, 0, 1, 0, 0);
        end
        drain("drain_imm");

        // Flush with ADDI x4 held in the issue register
        cycle(1, 32'h00100213, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(1, 32'h00100293, 0, 0, 0);
        chk("fl_busy_pre", dut.busy[4], 1);
        cycle(1, 32'h00100313, 0, 1, 0);
        cycle(0, 0, 1, 0, 0);
        chk("fl_valid", o_ex_valid, 0);
        chk("fl_busy", dut.busy[4], 0);
        chk("fl_ifready", o_if_ready, 1);
        chk("fl_stall", o_stall, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        chk("fl_empty", o_ex_valid, 0);
        drain("drain_flush");

        // Randomized traffic with automatic write-back
        auto_wb = 1;
        for (int i = 0; i < 3000; i++) begin
            bit fl, rdy, v;
            if (i == 1500) do_reset();
            fl  = ($urandom_range(0, 99) < 3);
            rdy = fl ? 1'b0 : ($urandom_range(0, 99) < 70);
            v   = ($urandom_range(0, 99) < 70);
            cycle(v, rand_instr(), rdy, fl, 0);
        end
        for (int k = 0; k < 300; k++) begin
            if (expq.size() == 0 && wbq.size() == 0 && !o_ex_valid) break;
            cycle(0, 0, 1, 0, 0);
        end
        chk("final_drain", 160'(expq.size() + wbq.size()), 160'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
